// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus for the program loader.
interface program_loader_if #(
    parameter int WORD_W = 49,
    parameter int ADDR_W = 6
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    // Loader side: consumes bytes, drives the memory write port.
    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    // Environment side: byte source and instruction memory.
    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: assembles a serial byte stream into instruction words,
// writes them to instruction memory, verifies a trailing XOR checksum and
// releases the CPU from hold only after a fully verified load.
module program_loader #(
    parameter int WORD_W = 49,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    program_loader_if.master  bus
);

    // Bytes per word, the index of the final byte, and how many of its bits
    // carry instruction data (the rest are pad bits that must be zero).
    localparam int NBYTES    = (WORD_W + 7) / 8;
    localparam int BUF_W     = (NBYTES - 1) * 8;
    localparam int LAST_BITS = WORD_W - BUF_W;
    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_PAD   = 2'b10;
    localparam logic [1:0] ERR_CHK   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        chk_q, chk_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              ready;
    logic              fire;
    logic              last_word;
    logic              pad_bad;
    logic              count_bad;

    assign ready     = (state_q == RECV) || (state_q == CHECK);
    assign fire      = ready && bus.byte_valid;
    assign last_word = ({1'b0, wr_addr_q} == (word_count_q - {{ADDR_W{1'b0}}, 1'b1}));
    assign pad_bad   = ((bus.byte_data >> LAST_BITS) != 8'd0);
    assign count_bad = (word_count == '0) || (word_count > MAX_WORDS);

    assign bus.byte_ready = ready;
    assign bus.wr_en      = (state_q == WRITE);
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign busy           = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_code       = err_code_q;

    // State register and datapath registers; reset aborts any session at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            word_count_q <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            buf_q        <= '0;
            byte_idx_q   <= '0;
            chk_q        <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            buf_q        <= buf_d;
            byte_idx_q   <= byte_idx_d;
            chk_q        <= chk_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    // Next-state logic: byte assembly, write sequencing and checksum verdict.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        buf_d        = buf_q;
        byte_idx_d   = byte_idx_q;
        chk_d        = chk_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    if (count_bad) begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_COUNT;
                    end else begin
                        state_d      = RECV;
                        word_count_d = word_count;
                        wr_addr_d    = '0;
                        byte_idx_d   = '0;
                        chk_d        = '0;
                        error_d      = 1'b0;
                        err_code_d   = ERR_NONE;
                    end
                end
            end

            RECV: begin
                if (fire) begin
                    chk_d = chk_q ^ bus.byte_data;
                    if (byte_idx_q == LAST_IDX) begin
                        if (pad_bad) begin
                            state_d    = ERROR;
                            error_d    = 1'b1;
                            err_code_d = ERR_PAD;
                        end else begin
                            wr_data_d = {bus.byte_data[LAST_BITS-1:0], buf_q};
                            state_d   = WRITE;
                        end
                    end else begin
                        buf_d[{byte_idx_q, 3'b000} +: 8] = bus.byte_data;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end

            WRITE: begin
                if (last_word) begin
                    state_d = CHECK;
                end else begin
                    wr_addr_d  = wr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    byte_idx_d = '0;
                    state_d    = RECV;
                end
            end

            CHECK: begin
                if (fire) begin
                    if (bus.byte_data == chk_q) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = ERROR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: single-word loads, checksum and pad
// errors, illegal counts, a full 64-word load and mid-session reset.
module tb_program_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] word_count;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    int errCount   = 0;
    int checkCount = 0;

    logic [5:0]  wrAddrQ[$];
    logic [48:0] wrDataQ[$];

    program_loader_if #(.WORD_W(49), .ADDR_W(6)) bus ();

    program_loader #(.WORD_W(49), .ADDR_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wrAddrQ.push_back(bus.wr_addr);
            wrDataQ.push_back(bus.wr_data);
        end
    end

    function automatic logic [7:0] word_chk(input logic [48:0] w);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < 6; k++) c = c ^ w[k*8 +: 8];
        c = c ^ {7'd0, w[48]};
        return c;
    endfunction

    task automatic clear_log();
        wrAddrQ.delete();
        wrDataQ.delete();
    endtask

    task automatic do_start(input logic [6:0] wc);
        @(negedge clk);
        start = 1'b1;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte and wait (bounded) until the loader takes it; returns 1ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  waited;
        bit  got;
        for (int i = 0; i < gap; i++) @(negedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        waited = 0;
        got = 0;
        while (!got && waited < 100) begin
            if (bus.byte_ready === 1'b1) begin
                @(posedge clk);
                #1;
                got = 1;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        bus.byte_valid = 1'b0;
        checkCount++;
        if (!got) begin
            errCount++;
            $display("[TB] FAIL byte_accept: byte %02h not accepted, got timeout, required acceptance", b);
        end
    endtask

    task automatic send_word(input logic [48:0] w, input int maxGap);
        for (int k = 0; k < 6; k++) send_byte(w[k*8 +: 8], $urandom_range(0, maxGap));
        send_byte({7'd0, w[48]}, $urandom_range(0, maxGap));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        checkCount++; if (bus.byte_ready !== 1'b0) begin errCount++; $display("[TB] FAIL reset_ready: got %b required 0", bus.byte_ready); end
        checkCount++; if (bus.wr_en !== 1'b0) begin errCount++; $display("[TB] FAIL reset_wr_en: got %b required 0", bus.wr_en); end
        checkCount++; if (bus.wr_addr !== 6'd0) begin errCount++; $display("[TB] FAIL reset_wr_addr: got %0d required 0", bus.wr_addr); end
        checkCount++; if (bus.wr_data !== 49'd0) begin errCount++; $display("[TB] FAIL reset_wr_data: got %h required 0", bus.wr_data); end
        checkCount++; if (cpu_hold !== 1'b1) begin errCount++; $display("[TB] FAIL reset_cpu_hold: got %b required 1", cpu_hold); end
        checkCount++; if ({done, error, err_code} !== 4'b0000) begin errCount++; $display("[TB] FAIL reset_status: got %b required 0000", {done, error, err_code}); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        clear_log();
        do_start(7'd1);
        checkCount++; if (busy !== 1'b1) begin errCount++; $display("[TB] FAIL single_busy: got %b required 1", busy); end
        send_word(49'h01665544332211, 0);
        checkCount++; if (bus.wr_en !== 1'b1) begin errCount++; $display("[TB] FAIL single_wr_latency: got %b required 1", bus.wr_en); end
        checkCount++; if (bus.wr_addr !== 6'd0) begin errCount++; $display("[TB] FAIL single_wr_addr: got %0d required 0", bus.wr_addr); end
        checkCount++; if (bus.wr_data !== 49'h01665544332211) begin errCount++; $display("[TB] FAIL single_wr_data: got %h required 01665544332211", bus.wr_data); end
        do_start(7'd0);
        checkCount++; if (error !== 1'b0 || busy !== 1'b1) begin errCount++; $display("[TB] FAIL start_while_busy: got error=%b busy=%b required error=0 busy=1", error, busy); end
        send_byte(8'h76, 0);
        checkCount++; if (done !== 1'b1) begin errCount++; $display("[TB] FAIL single_done: got %b required 1", done); end
        checkCount++; if (cpu_hold !== 1'b0) begin errCount++; $display("[TB] FAIL single_cpu_hold: got %b required 0", cpu_hold); end
        checkCount++; if (error !== 1'b0 || err_code !== 2'b00) begin errCount++; $display("[TB] FAIL single_no_error: got error=%b code=%b required 0/00", error, err_code); end
        checkCount++; if (busy !== 1'b0 || bus.byte_ready !== 1'b0) begin errCount++; $display("[TB] FAIL single_idle: got busy=%b ready=%b required 0/0", busy, bus.byte_ready); end
        repeat (2) @(negedge clk);
        checkCount++; if (wrAddrQ.size() != 1) begin errCount++; $display("[TB] FAIL single_write_count: got %0d required 1", wrAddrQ.size()); end
        checkCount++; if (bus.wr_data !== 49'h01665544332211) begin errCount++; $display("[TB] FAIL single_data_hold: got %h required 01665544332211", bus.wr_data); end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        do_start(7'd1);
        checkCount++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin errCount++; $display("[TB] FAIL restart_hold: got hold=%b done=%b required 1/0", cpu_hold, done); end
        send_word(49'h01665544332211, 1);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        checkCount++; if (error !== 1'b1 || err_code !== 2'b11) begin errCount++; $display("[TB] FAIL bad_chk_error: got error=%b code=%b required 1/11", error, err_code); end
        checkCount++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin errCount++; $display("[TB] FAIL bad_chk_hold: got hold=%b done=%b required 1/0", cpu_hold, done); end
        checkCount++; if (wrAddrQ.size() != 1) begin errCount++; $display("[TB] FAIL bad_chk_writes: got %0d required 1", wrAddrQ.size()); end
    endtask

    task automatic test_illegal_count();
        clear_log();
        do_start(7'd0);
        checkCount++; if (error !== 1'b1 || err_code !== 2'b01) begin errCount++; $display("[TB] FAIL count0_error: got error=%b code=%b required 1/01", error, err_code); end
        checkCount++; if (busy !== 1'b0 || bus.byte_ready !== 1'b0) begin errCount++; $display("[TB] FAIL count0_idle: got busy=%b ready=%b required 0/0", busy, bus.byte_ready); end
        do_start(7'd65);
        checkCount++; if (error !== 1'b1 || err_code !== 2'b01) begin errCount++; $display("[TB] FAIL count65_error: got error=%b code=%b required 1/01", error, err_code); end
        checkCount++; if (cpu_hold !== 1'b1) begin errCount++; $display("[TB] FAIL count65_hold: got %b required 1", cpu_hold); end
        repeat (3) @(negedge clk);
        checkCount++; if (wrAddrQ.size() != 0) begin errCount++; $display("[TB] FAIL illegal_writes: got %0d required 0", wrAddrQ.size()); end
    endtask

    task automatic test_pad_error();
        clear_log();
        do_start(7'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h02, 0);
        checkCount++; if (error !== 1'b1 || err_code !== 2'b10) begin errCount++; $display("[TB] FAIL pad_error: got error=%b code=%b required 1/10", error, err_code); end
        repeat (3) @(negedge clk);
        checkCount++; if (wrAddrQ.size() != 0) begin errCount++; $display("[TB] FAIL pad_writes: got %0d required 0", wrAddrQ.size()); end
        checkCount++; if (busy !== 1'b0 || done !== 1'b0) begin errCount++; $display("[TB] FAIL pad_state: got busy=%b done=%b required 0/0", busy, done); end
    endtask

    task automatic test_full_64();
        logic [48:0] expWords[64];
        logic [7:0]  chk;
        clear_log();
        chk = 8'h00;
        for (int w = 0; w < 64; w++) begin
            expWords[w] = {$urandom_range(0, 1) == 1, 16'($urandom), 32'($urandom)};
            chk = chk ^ word_chk(expWords[w]);
        end
        do_start(7'd64);
        for (int w = 0; w < 64; w++) send_word(expWords[w], 2);
        send_byte(chk, 1);
        repeat (2) @(negedge clk);
        checkCount++; if (wrAddrQ.size() != 64) begin errCount++; $display("[TB] FAIL full_write_count: got %0d required 64", wrAddrQ.size()); end
        for (int w = 0; w < 64; w++) begin
            if (w < wrAddrQ.size()) begin
                checkCount++; if (wrAddrQ[w] !== 6'(w)) begin errCount++; $display("[TB] FAIL full_addr[%0d]: got %0d required %0d", w, wrAddrQ[w], w); end
                checkCount++; if (wrDataQ[w] !== expWords[w]) begin errCount++; $display("[TB] FAIL full_data[%0d]: got %h required %h", w, wrDataQ[w], expWords[w]); end
            end
        end
        checkCount++; if (done !== 1'b1 || error !== 1'b0) begin errCount++; $display("[TB] FAIL full_done: got done=%b error=%b required 1/0", done, error); end
        checkCount++; if (bus.wr_addr !== 6'd63) begin errCount++; $display("[TB] FAIL full_last_addr: got %0d required 63", bus.wr_addr); end
    endtask

    task automatic test_reset_mid();
        logic [48:0] w0;
        logic [48:0] w1;
        int beforeCount;
        clear_log();
        do_start(7'd8);
        for (int w = 0; w < 3; w++) send_word({1'b0, 8'(w), 40'h0A0B0C0D0E}, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        beforeCount = wrAddrQ.size();
        checkCount++; if (beforeCount != 3) begin errCount++; $display("[TB] FAIL mid_pre_writes: got %0d required 3", beforeCount); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkCount++; if (busy !== 1'b0 || bus.byte_ready !== 1'b0 || bus.wr_en !== 1'b0) begin errCount++; $display("[TB] FAIL mid_reset_ctrl: got busy=%b ready=%b wr_en=%b required 000", busy, bus.byte_ready, bus.wr_en); end
        checkCount++; if (bus.wr_addr !== 6'd0 || bus.wr_data !== 49'd0) begin errCount++; $display("[TB] FAIL mid_reset_bus: got addr=%0d data=%h required 0/0", bus.wr_addr, bus.wr_data); end
        checkCount++; if (cpu_hold !== 1'b1 || {done, error, err_code} !== 4'b0000) begin errCount++; $display("[TB] FAIL mid_reset_status: got hold=%b status=%b required 1/0000", cpu_hold, {done, error, err_code}); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        repeat (8) @(negedge clk);
        bus.byte_valid = 1'b0;
        checkCount++; if (wrAddrQ.size() != beforeCount || busy !== 1'b0) begin errCount++; $display("[TB] FAIL mid_no_restart: got writes=%0d busy=%b required %0d/0", wrAddrQ.size(), busy, beforeCount); end
        clear_log();
        w0 = 49'h1_0123_4567_89AB;
        w1 = 49'h0_FEDC_BA98_7654;
        do_start(7'd2);
        send_word(w0, 1);
        send_word(w1, 1);
        send_byte(word_chk(w0) ^ word_chk(w1), 0);
        repeat (2) @(negedge clk);
        checkCount++; if (wrAddrQ.size() != 2) begin errCount++; $display("[TB] FAIL reload_writes: got %0d required 2", wrAddrQ.size()); end
        if (wrAddrQ.size() == 2) begin
            checkCount++; if (wrAddrQ[0] !== 6'd0 || wrAddrQ[1] !== 6'd1) begin errCount++; $display("[TB] FAIL reload_addr: got %0d,%0d required 0,1", wrAddrQ[0], wrAddrQ[1]); end
            checkCount++; if (wrDataQ[0] !== w0 || wrDataQ[1] !== w1) begin errCount++; $display("[TB] FAIL reload_data: got %h,%h required %h,%h", wrDataQ[0], wrDataQ[1], w0, w1); end
        end
        checkCount++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errCount++; $display("[TB] FAIL reload_done: got done=%b hold=%b required 1/0", done, cpu_hold); end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        word_count = 7'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_single_word();
        test_bad_checksum();
        test_illegal_count();
        test_pad_error();
        test_full_64();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
